// File: rtl/fwspi_memio_rdseq_if.sv
// Bundle between the word-read requester / byte engine (master) and the read sequencer (slave).
interface fwspi_memio_rdseq_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [23:0] rd_addr;
  logic [31:0] rd_rdata;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_dummy;
  logic        xfer_resetn;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  din_data;
  logic [3:0]  din_tag;
  logic        din_cont;
  logic        din_dspi;
  logic        din_qspi;
  logic        din_ddr;
  logic        din_rd;
  logic        dout_valid;
  logic [7:0]  dout_data;
  logic [3:0]  dout_tag;

  modport master (
    output rd_valid, rd_addr, cfg_mode, cfg_dummy, din_ready, dout_valid, dout_data, dout_tag,
    input  rd_ready, rd_rdata, xfer_resetn, din_valid, din_data, din_tag,
           din_cont, din_dspi, din_qspi, din_ddr, din_rd
  );

  modport slave (
    input  rd_valid, rd_addr, cfg_mode, cfg_dummy, din_ready, dout_valid, dout_data, dout_tag,
    output rd_ready, rd_rdata, xfer_resetn, din_valid, din_data, din_tag,
           din_cont, din_dspi, din_qspi, din_ddr, din_rd
  );
endinterface

// File: rtl/fwspi_memio_rdseq.sv
// Word-read sequencer: emits cmd/addr/mode/read byte entries to the SPI byte engine,
// reassembles the returned bytes little-endian and keeps CSB low across sequential reads.
module fwspi_memio_rdseq (
  input logic clk,
  input logic reset,
  fwspi_memio_rdseq_if.slave bus
);
  typedef enum logic [3:0] {IDLE, DESEL, CMD, A2, A1, A0, MODE, RD, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic        burst_open;
  logic [23:0] next_addr, addr_q;
  logic [1:0]  mode_q;
  logic [3:0]  dummy_q;
  logic        first;
  logic [1:0]  rd_cnt;
  logic [31:0] rdata_q;
  logic        resetn_q;

  logic        cont_hit, accept;
  logic [7:0]  cmd_byte;
  logic        w_dspi, w_qspi, w_ddr;

  logic        rd_ready, xfer_resetn, din_valid, din_cont, din_dspi, din_qspi, din_ddr, din_rd;
  logic [7:0]  din_data;
  logic [3:0]  din_tag;

  // next_addr == 0 means the previous word ended at the top of flash; never continue across the wrap
  assign cont_hit = burst_open && (bus.rd_addr == next_addr) && (next_addr != 24'd0) &&
                    (bus.cfg_mode == mode_q) && (bus.cfg_dummy == dummy_q);
  assign accept   = din_valid && bus.din_ready;
  assign w_dspi   = (mode_q == 2'd1);
  assign w_qspi   = mode_q[1];
  assign w_ddr    = (mode_q == 2'd3);

  always_comb begin
    case (mode_q)
      2'd0:    cmd_byte = 8'h03;
      2'd1:    cmd_byte = 8'hBB;
      2'd2:    cmd_byte = 8'hEB;
      default: cmd_byte = 8'hED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    rd_ready    = 1'b0;
    xfer_resetn = 1'b1;
    din_valid   = 1'b0;
    din_data    = 8'h00;
    din_tag     = 4'h0;
    din_cont    = 1'b0;
    din_dspi    = 1'b0;
    din_qspi    = 1'b0;
    din_ddr     = 1'b0;
    din_rd      = 1'b0;
    case (state)
      IDLE: begin
        xfer_resetn = resetn_q;
        if (bus.rd_valid) state_nx = cont_hit ? RD : DESEL;
      end
      DESEL: begin
        xfer_resetn = 1'b0;
        state_nx    = CMD;
      end
      CMD: begin
        din_valid = 1'b1;
        din_cont  = 1'b1;
        din_data  = cmd_byte;
        if (bus.din_ready) state_nx = A2;
      end
      A2, A1, A0, MODE: begin
        din_valid = 1'b1;
        din_cont  = 1'b1;
        din_dspi  = w_dspi;
        din_qspi  = w_qspi;
        din_ddr   = w_ddr;
        case (state)
          A2:      din_data = addr_q[23:16];
          A1:      din_data = addr_q[15:8];
          A0:      din_data = addr_q[7:0];
          default: din_data = 8'h00;
        endcase
        if (bus.din_ready) begin
          case (state)
            A2:      state_nx = A1;
            A1:      state_nx = A0;
            A0:      state_nx = (mode_q == 2'd0) ? RD : MODE;
            default: state_nx = RD;
          endcase
        end
      end
      RD: begin
        din_valid = 1'b1;
        din_cont  = 1'b1;
        din_rd    = 1'b1;
        din_dspi  = w_dspi;
        din_qspi  = w_qspi;
        din_ddr   = w_ddr;
        din_tag   = {2'b00, rd_cnt} + 4'd1;
        if (first && (rd_cnt == 2'd0) && (mode_q != 2'd0)) din_data = {4'h0, dummy_q};
        if (bus.din_ready && (rd_cnt == 2'd3)) state_nx = WAIT;
      end
      WAIT: begin
        if (bus.dout_valid && (bus.dout_tag == 4'd4)) state_nx = DONE;
      end
      DONE: begin
        rd_ready = bus.rd_valid;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_open <= 1'b0;
      next_addr  <= 24'd0;
      addr_q     <= 24'd0;
      mode_q     <= 2'd0;
      dummy_q    <= 4'd0;
      first      <= 1'b0;
      rd_cnt     <= 2'd0;
      rdata_q    <= 32'd0;
      resetn_q   <= 1'b0;
    end else begin
      resetn_q <= xfer_resetn;
      if (state == IDLE && bus.rd_valid && cont_hit) begin
        addr_q <= bus.rd_addr;
        first  <= 1'b0;
      end
      if (state == DESEL) begin
        mode_q  <= bus.cfg_mode;
        dummy_q <= bus.cfg_dummy;
        addr_q  <= bus.rd_addr;
        first   <= 1'b1;
      end
      if (state != RD) rd_cnt <= 2'd0;
      else if (accept) rd_cnt <= rd_cnt + 2'd1;
      // returns may overlap the tail of the RD entries, so capture in both states
      if ((state == RD || state == WAIT) && bus.dout_valid) begin
        case (bus.dout_tag)
          4'd1:    rdata_q[7:0]   <= bus.dout_data;
          4'd2:    rdata_q[15:8]  <= bus.dout_data;
          4'd3:    rdata_q[23:16] <= bus.dout_data;
          4'd4:    rdata_q[31:24] <= bus.dout_data;
          default: ;
        endcase
      end
      if (state == DONE) begin
        next_addr  <= addr_q + 24'd4;
        burst_open <= 1'b1;
      end
    end
  end

  assign bus.rd_ready    = rd_ready;
  assign bus.rd_rdata    = rdata_q;
  assign bus.xfer_resetn = xfer_resetn;
  assign bus.din_valid   = din_valid;
  assign bus.din_data    = din_data;
  assign bus.din_tag     = din_tag;
  assign bus.din_cont    = din_cont;
  assign bus.din_dspi    = din_dspi;
  assign bus.din_qspi    = din_qspi;
  assign bus.din_ddr     = din_ddr;
  assign bus.din_rd      = din_rd;
endmodule

// File: doc/fwspi_memio_rdseq.md
# fwspi_memio_rdseq

Read sequencer directly upstream of the byte-level SPI transfer engine in the fwspi memio path. Turns a 32-bit word read request at a 24-bit flash byte address into a command/address/read byte stream with per-byte width controls. Reassembles the four returned data bytes into a little-endian word. Keeps chip-select low across sequential word reads, so a burst pays for command and address only once.

## Interface
Parameters: none.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_valid  in  1  read request; held with rd_addr stable until rd_ready
- rd_ready  out  1  one-cycle pulse; rd_rdata valid in the same cycle
- rd_addr  in  24  flash byte address
- rd_rdata  out  32  read word; byte at rd_addr in [7:0], rd_addr+3 in [31:24]
- cfg_mode  in  2  0 single (0x03), 1 dual I/O (0xBB), 2 quad I/O (0xEB), 3 quad DDR (0xED)
- cfg_dummy  in  4  dummy clocks before the first data byte; ignored in mode 0
- xfer_resetn  out  1  low deselects the engine (CSB high)
- din_valid  out  1  byte entry to the engine
- din_ready  in  1  entry accepted this cycle
- din_data  out  8  byte to shift, or dummy count when din_rd=1
- din_tag  out  4  0 = overhead byte, 1..4 = data byte 0..3
- din_cont, din_dspi, din_qspi, din_ddr, din_rd  out  1 each  per-entry controls
- dout_valid  in  1  returned byte strobe
- dout_data  in  8  returned byte
- dout_tag  in  4  tag of the returned byte

## Operation
- Reset values: rd_ready=0, rd_rdata=0, xfer_resetn=0, din_valid=0, din_data=0, din_tag=0, all din_* controls 0. State IDLE, burst_open=0.
- States:
  - IDLE, DESEL, CMD, A2, A1, A0, MODE, RD, WAIT, DONE.
- Entry flow:
  - An entry is issued with din_valid=1. It is held constant until the cycle with din_ready=1, then the FSM advances.
- IDLE:
  - On rd_valid, continuation is true when burst_open=1, rd_addr == next_addr, next_addr != 0, and cfg_mode/cfg_dummy equal their latched values.
  - Continuation -> RD with first=0. Otherwise -> DESEL.
- DESEL:
  - xfer_resetn=0 for exactly one cycle.
  - Latch cfg_mode, cfg_dummy and rd_addr, then go to CMD.
  - xfer_resetn=1 in every other non-IDLE state. In IDLE it keeps its previous value.
- CMD:
  - Command byte per mode, single-bit width (dspi=qspi=ddr=0), rd=0, tag 0.
- A2/A1/A0:
  - Address bits [23:16], [15:8], [7:0] at mode width: mode 0 single, 1 dspi, 2 qspi, 3 qspi+ddr. Tag 0.
- MODE:
  - Byte 0x00 at mode width, tag 0. Skipped in mode 0.
- RD:
  - Four entries with tags 1..4, din_rd=1, mode width.
  - First entry after an address phase: din_data = (mode 0 ? 0 : cfg_dummy). All other entries: din_data = 0.
  - After tag 4 is accepted -> WAIT.
- WAIT:
  - Capture dout_data into byte lane (tag-1) when dout_valid and tag is 1..4.
  - Ignore tag 0 returns.
  - Tag 4 return -> DONE.
- DONE:
  - rd_ready=1 for one cycle if rd_valid is still high. If rd_valid has dropped, the word is discarded.
  - next_addr = latched addr + 4 (24-bit), burst_open=1, then -> IDLE.
- din_cont = 1 on every entry.
- The latched address updates to rd_addr on continuation.
- CSB remains low while idle in an open burst.

## Timing
- Fresh read latency, rd_valid to rd_ready: 1 (DESEL) + 8 or 9 byte entries + engine shift time + 1.
- Continuation read issues no DESEL, CMD or address entries.
- next_addr == 0 forces a deselect. Bursts never continue across the 0xFFFFFC -> 0x000000 wrap.
- A cfg change between reads forces a deselect. A cfg change mid-read has no effect, because values are latched in DESEL.
- Reset mid-operation: the FSM goes to IDLE and xfer_resetn goes low on the next edge. The partial word is lost and rd_ready stays 0.
- Data capture relies only on dout_valid and dout_tag, so the DDR one-cycle-delayed return needs no special handling.

## Test plan
- Mode 0, rd_addr=0x000100, flash memory 0x11,0x22,0x33,0x44 -> entries 0x03,0x00,0x01,0x00, then four rd entries with din_data=0; rd_rdata=0x44332211; one rd_ready pulse.
- Mode 2, cfg_dummy=4, addr 0x123454 -> CMD 0xEB single-bit, address and 0x00 mode byte qspi, first rd entry din_data=4 -> correct word returned.
- Sequential burst 0x000200 then 0x000204 -> second read issues no DESEL/CMD/address; xfer_resetn never drops between the two reads.
- Non-sequential 0x000200 then 0x000300, and separately 0xFFFFFC then 0x000000 -> xfer_resetn low exactly one cycle, followed by a full command sequence.
- Mode 3 DDR read at 0x000010 -> cmd 0xED; returned bytes land in the correct lanes despite delayed dout_valid.
- Reset asserted in WAIT -> rd_ready is never asserted, xfer_resetn=0 next cycle; a subsequent read at the old next_addr performs a full DESEL sequence.
